// File: rtl/item_slot_manager_pkg.sv
//----------------------------------------------------------------------------
// item_pkg : shared sizes and types for the item slot manager
// Rev 1.0 : initial release
//----------------------------------------------------------------------------
`default_nettype none

package item_pkg;

  localparam int          ITEM_SLOTS     = 6;
  localparam int          ITEM_TYPES     = 7;
  localparam logic [2:0]  ITEM_TYPE_NONE = 3'd7;
  localparam logic [2:0]  LAST_IDX       = 3'(ITEM_SLOTS - 1);

  typedef struct packed {
    logic       occupied;
    logic [2:0] kind;
  } item_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_USE = 1'b1
  } op_t;

endpackage

`default_nettype wire

// File: rtl/item_slot_manager_arb.sv
//----------------------------------------------------------------------------
// item_req_arb : 2-way round-robin arbiter between add and use requesters
// Rev 1.0 : initial release
//----------------------------------------------------------------------------
`default_nettype none

module item_req_arb (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_add_req,
  input  logic i_use_req,
  output logic o_grant_add,
  output logic o_grant_use
);

  // favour_add_q=0 means the use port wins a tie
  logic favour_add_q;
  logic favour_add_d;

  always_comb begin
    o_grant_add  = i_en & i_add_req & (~i_use_req | favour_add_q);
    o_grant_use  = i_en & i_use_req & (~i_add_req | ~favour_add_q);
    favour_add_d = favour_add_q;
    if (o_grant_add) begin
      favour_add_d = 1'b0;
    end else if (o_grant_use) begin
      favour_add_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      favour_add_q <= 1'b0;
    end else begin
      favour_add_q <= favour_add_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/item_slot_manager.sv
//----------------------------------------------------------------------------
// item_slot_manager : owns six item slots, serves add/use requests by scan
// Rev 1.0 : initial release
//----------------------------------------------------------------------------
`default_nettype none

module item_slot_manager
  import item_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_add_valid,
  input  logic [2:0] i_add_type,
  output logic       o_add_ready,
  input  logic       i_use_valid,
  input  logic [2:0] i_use_type,
  output logic       o_use_ready,
  input  logic       i_clear,
  output logic       o_done,
  output logic       o_ok,
  output logic [3:0] o_item0,
  output logic [3:0] o_item1,
  output logic [3:0] o_item2,
  output logic [3:0] o_item3,
  output logic [3:0] o_item4,
  output logic [3:0] o_item5,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_busy
);

  state_t     state_q, state_d;
  op_t        op_q, op_d;
  logic [2:0] kind_q, kind_d;
  logic [2:0] idx_q, idx_d;
  logic       ok_q, ok_d;
  item_t      slot_q [ITEM_SLOTS];
  item_t      slot_d [ITEM_SLOTS];

  logic       w_arb_en;
  logic       w_grant_add;
  logic       w_grant_use;
  logic       w_start;
  logic [2:0] w_req_kind;
  item_t      w_cur;
  logic       w_hit;
  logic       w_last;

  assign w_arb_en   = (state_q == IDLE) & ~i_clear;
  assign w_start    = w_grant_add | w_grant_use;
  assign w_req_kind = w_grant_use ? i_use_type : i_add_type;
  assign w_last     = (idx_q == LAST_IDX);

  item_req_arb u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (w_arb_en),
    .i_add_req   (i_add_valid),
    .i_use_req   (i_use_valid),
    .o_grant_add (w_grant_add),
    .o_grant_use (w_grant_use)
  );

  // Slot under the scan pointer and whether it satisfies the pending op
  always_comb begin
    w_cur = '0;
    for (int i = 0; i < ITEM_SLOTS; i++) begin
      if (idx_q == 3'(i)) begin
        w_cur = slot_q[i];
      end
    end
    if (op_q == OP_ADD) begin
      w_hit = ~w_cur.occupied;
    end else begin
      w_hit = w_cur.occupied & (w_cur.kind == kind_q);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_start) begin
            state_d = (w_req_kind == ITEM_TYPE_NONE) ? RESP : SCAN;
          end
        end
        SCAN: begin
          if (w_hit || w_last) begin
            state_d = RESP;
          end
        end
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: request latch, scan index, result flag and slot writes
  always_comb begin
    op_d   = op_q;
    kind_d = kind_q;
    idx_d  = idx_q;
    ok_d   = ok_q;
    slot_d = slot_q;
    if (i_clear) begin
      ok_d = 1'b0;
      for (int i = 0; i < ITEM_SLOTS; i++) begin
        slot_d[i] = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (w_start) begin
            op_d   = w_grant_use ? OP_USE : OP_ADD;
            kind_d = w_req_kind;
            idx_d  = 3'd0;
            ok_d   = 1'b0;
          end
        end
        SCAN: begin
          if (w_hit) begin
            ok_d = 1'b1;
            for (int i = 0; i < ITEM_SLOTS; i++) begin
              if (idx_q == 3'(i)) begin
                if (op_q == OP_ADD) begin
                  slot_d[i].occupied = 1'b1;
                  slot_d[i].kind     = kind_q;
                end else begin
                  slot_d[i] = '0;
                end
              end
            end
          end else if (w_last) begin
            ok_d = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      kind_q  <= 3'd0;
      idx_q   <= 3'd0;
      ok_q    <= 1'b0;
      for (int i = 0; i < ITEM_SLOTS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      kind_q  <= kind_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      slot_q  <= slot_d;
    end
  end

  // Output logic
  always_comb begin
    o_add_ready = w_grant_add;
    o_use_ready = w_grant_use;
    o_done      = (state_q == RESP);
    o_ok        = ok_q & (state_q == RESP);
    o_busy      = (state_q != IDLE);
    o_full      = 1'b1;
    o_empty     = 1'b1;
    for (int i = 0; i < ITEM_SLOTS; i++) begin
      o_full  = o_full & slot_q[i].occupied;
      o_empty = o_empty & ~slot_q[i].occupied;
    end
  end

  assign o_item0 = slot_q[0];
  assign o_item1 = slot_q[1];
  assign o_item2 = slot_q[2];
  assign o_item3 = slot_q[3];
  assign o_item4 = slot_q[4];
  assign o_item5 = slot_q[5];

endmodule

`default_nettype wire
